core_dispatcher: RTL
====================

Name: core_dispatcher

Overview:
- Job scheduler in front of the N-instance cnn_top array.
- Buffers incoming image-job IDs in a FIFO and dispatches each to a free core with a one-cycle start pulse.
- Captures each core's prediction on completion and returns results through a valid/ready stream tagged with job ID and core index.
- Replaces the fixed "start all, wait for all" sequencing with continuous, out-of-order job issue.

Parameters:
- N_CORES, 4, number of cnn_top cores scheduled (≥2).
- JOB_ID_W, 8, job/image-slot identifier width.
- RESULT_W, 32, prediction width from each core.
- QDEPTH, 8, job FIFO depth (power of 2).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- job_valid  in  1  job offered
- job_ready  out  1  FIFO not full
- job_id  in  JOB_ID_W  image slot to process
- core_start  out  N_CORES  one-cycle start pulse per core
- core_job_id  out  N_CORES*JOB_ID_W  per-core image select, stable from start until result drained
- core_done  in  N_CORES  one-cycle completion pulse per core
- core_value  in  N_CORES*RESULT_W  per-core prediction, valid with core_done
- res_valid  out  1  result available
- res_ready  in  1  result consumer ready
- res_id  out  JOB_ID_W  job ID of result
- res_core  out  clog2(N_CORES)  core that produced the result
- res_value  out  RESULT_W  prediction
- outstanding  out  clog2(QDEPTH+N_CORES)+1  jobs accepted but not yet returned
- idle  out  1  FIFO empty and all cores IDLE
- err_spurious  out  1  sticky flag: core_done seen on a non-RUN core

Behaviour:
- Reset values:
  - core_start=0, core_job_id=0, res_valid=0, res_id/res_core/res_value=0.
  - outstanding=0, idle=1, err_spurious=0, job_ready=1.
  - FIFO is emptied and every core slot is set to IDLE.
- Job acceptance:
  - A job is accepted on job_valid&&job_ready.
  - job_ready = !full, combinational from the FIFO count.
  - Accept and pop in the same cycle while full is allowed; occupancy is unchanged.
- Per-core slot FSM:
  - IDLE→RUN: on dispatch. In the same edge, core_start[k]<=1 for exactly one cycle and core_job_id[k]<=FIFO head.
  - RUN→HOLD: on core_done[k]. Capture core_value[k] into the slot result register.
  - HOLD→IDLE: when that slot's result is transferred on res_valid&&res_ready.
  - A core is not re-dispatched until its result has drained. Backpressure therefore stalls issue.
- Dispatch:
  - At most one dispatch per cycle.
  - Condition: FIFO non-empty and at least one IDLE slot.
  - Grant: round-robin over IDLE slots, starting at disp_ptr. After a grant to k, disp_ptr=k+1 mod N_CORES.
  - A job accepted at edge t is dispatchable at edge t+1, so core_start is visible in cycle t+1→t+2. Minimum accept-to-start latency is 1 cycle.
  - A slot that enters IDLE at edge t is dispatchable at edge t+1 (no same-edge HOLD→IDLE→RUN).
- Result output:
  - Round-robin arbiter over HOLD slots, with pointer res_ptr.
  - res_* outputs are registered. Once res_valid=1, res_id/res_core/res_value stay stable until res_ready.
  - On transfer, res_ptr advances past the granted core, and the next HOLD slot (if any) is presented on the following edge. This gives back-to-back results at 1 per cycle.
  - core_done at edge t → res_valid at earliest edge t+1.
- Simultaneous events:
  - Multiple core_done in one cycle: all are captured.
  - core_done on core k while core k's result is being transferred: impossible, because k is in HOLD, not RUN. If it occurs, set err_spurious and ignore the pulse.
  - core_done on an IDLE slot: set err_spurious and ignore.
- outstanding:
  - +1 on accept, −1 on result transfer; both in one cycle gives net 0.
  - Never exceeds QDEPTH+N_CORES.
- idle = (FIFO empty) && (all slots IDLE), registered.
- Reset mid-operation:
  - All state clears in one edge, and in-flight results are discarded.
  - cnn_top shares rst, so the cores abort in the same edge.
  - No core_start is issued in the cycle after rst deasserts unless a job was accepted.

Decomposition:
- Shared package cnn_pkg holds:
  - slot state enum (SLOT_IDLE, SLOT_RUN, SLOT_HOLD);
  - localparams for default JOB_ID_W/RESULT_W;
  - function rr_pick(mask, ptr) returning the first set bit at or after ptr.
- Sub-module job_fifo (synchronous, QDEPTH×JOB_ID_W, with full/empty/count) is natural.
- Both arbiters use rr_pick inline.

Test Plan:
- Single job: job_id=8'h2A, core_done[0] 5 cycles after start with value 32'hDEAD_BEEF → core_start=4'b0001 one cycle; res_valid with res_id=2A, res_core=0, res_value=DEADBEEF; outstanding returns to 0; idle=1.
- Burst of 6 jobs (IDs 1–6), N_CORES=4, res_ready=1 → starts on cores 0,1,2,3 in 4 consecutive cycles. IDs 5,6 wait in the FIFO and dispatch to cores in round-robin order as results drain. All 6 IDs are returned exactly once.
- res_ready=0 with all 4 cores done → no further core_start; FIFO fills to 8; job_ready=0; outstanding=12. Raising res_ready drains results in round-robin core order, one per cycle.
- Out-of-order completion: core 3 done before core 0 → core 3's job ID is emitted first, with its res_core=3 and the correct value.
- Spurious core_done[2] while slot 2 is IDLE → err_spurious=1 (sticky); no res_valid; outstanding unchanged.
- rst asserted for 1 cycle with 3 cores RUN and 2 jobs queued → next cycle outstanding=0, idle=1, res_valid=0, job_ready=1, core_start=0.

Source files
------------

// File: rtl/core_dispatcher_pkg.sv
// Shared types and helpers for the core dispatcher slice.
//   slot_state_t : per-core scheduling slot state
//   DEF_*        : default job-ID and result widths
//   rr_pick      : round-robin pick of the first set mask bit at or after ptr
package core_dispatcher_pkg;

    typedef enum logic [1:0] {
        SLOT_IDLE = 2'd0,
        SLOT_RUN  = 2'd1,
        SLOT_HOLD = 2'd2
    } slot_state_t;

    localparam int DEF_JOB_ID_W = 8;
    localparam int DEF_RESULT_W = 32;

    // Upper bound on the core count the arbiter helper can scan.
    localparam int MAX_CORES = 32;

    // Returns the index of the first set bit of mask[n-1:0] found when scanning
    // upward from ptr with wrap-around, or -1 when no bit is set.  The loop runs
    // downward so the smallest offset from ptr is the last (winning) assignment.
    function automatic int rr_pick(input logic [MAX_CORES-1:0] mask,
                                   input int ptr,
                                   input int n);
        int idx;
        logic [MAX_CORES-1:0] sh;
        rr_pick = -1;
        for (int i = MAX_CORES - 1; i >= 0; i--) begin
            if (i < n) begin
                idx = ptr + i;
                if (idx >= n) idx = idx - n;
                sh = mask >> idx;
                if (sh[0]) rr_pick = idx;
            end
        end
    endfunction

endpackage

// File: rtl/core_dispatcher_if.sv
// Bundle of the dispatcher's three streams: job intake (valid/ready), the
// per-core start/done bus towards the cnn_top array, and the result stream
// (valid/ready).  The dispatcher uses the slave modport; the job source,
// cores and result consumer together form the master side.
interface core_dispatcher_if
    import core_dispatcher_pkg::*;
#(
    parameter int N_CORES  = 4,
    parameter int JOB_ID_W = DEF_JOB_ID_W,
    parameter int RESULT_W = DEF_RESULT_W
);
    localparam int CW = $clog2(N_CORES);

    logic                         job_valid;
    logic                         job_ready;
    logic [JOB_ID_W-1:0]          job_id;

    logic [N_CORES-1:0]           core_start;
    logic [N_CORES*JOB_ID_W-1:0]  core_job_id;
    logic [N_CORES-1:0]           core_done;
    logic [N_CORES*RESULT_W-1:0]  core_value;

    logic                         res_valid;
    logic                         res_ready;
    logic [JOB_ID_W-1:0]          res_id;
    logic [CW-1:0]                res_core;
    logic [RESULT_W-1:0]          res_value;

    modport master (
        output job_valid, job_id, core_done, core_value, res_ready,
        input  job_ready, core_start, core_job_id,
               res_valid, res_id, res_core, res_value
    );

    modport slave (
        input  job_valid, job_id, core_done, core_value, res_ready,
        output job_ready, core_start, core_job_id,
               res_valid, res_id, res_core, res_value
    );

endinterface

// File: rtl/core_dispatcher_job_fifo.sv
// Synchronous job-ID FIFO, DEPTH entries of W bits, first-word fall-through
// head on dout.
//   clk, rst      : clock, synchronous active-high reset (pointers/count only)
//   push, din     : write request and data (ignored when full unless popping)
//   pop, dout     : read request and current head entry
//   full, empty   : occupancy flags
//   count         : number of stored entries
module core_dispatcher_job_fifo #(
    parameter int DEPTH = 8,
    parameter int W     = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [W-1:0]             din,
    input  logic                     pop,
    output logic [W-1:0]             dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW   = $clog2(DEPTH);
    localparam int CNTW = AW + 1;

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign full    = (count == CNTW'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop && !empty;
    // A pop frees the slot being written, so a push at full is legal then.
    assign do_push = push && (!full || do_pop);
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            if (do_push && !do_pop)      count <= count + CNTW'(1);
            else if (!do_push && do_pop) count <= count - CNTW'(1);
        end
    end

endmodule

// File: rtl/core_dispatcher.sv
// Job scheduler in front of an array of N_CORES cnn_top instances.  Incoming
// job IDs are queued and issued to free cores with a one-cycle start pulse;
// each core's prediction is captured on completion and returned through a
// registered valid/ready result stream tagged with job ID and core index.
//   clk, rst      : clock, synchronous active-high reset
//   bus (slave)   : job intake, core start/done bus, result stream
//   outstanding   : jobs accepted but not yet returned
//   idle          : registered "FIFO empty and every slot IDLE"
//   err_spurious  : sticky, set by core_done on a core that was not running
module core_dispatcher
    import core_dispatcher_pkg::*;
#(
    parameter int N_CORES  = 4,
    parameter int JOB_ID_W = DEF_JOB_ID_W,
    parameter int RESULT_W = DEF_RESULT_W,
    parameter int QDEPTH   = 8
) (
    input  logic                                clk,
    input  logic                                rst,
    core_dispatcher_if.slave                    bus,
    output logic [$clog2(QDEPTH+N_CORES):0]     outstanding,
    output logic                                idle,
    output logic                                err_spurious
);
    localparam int CW    = $clog2(N_CORES);
    localparam int OUT_W = $clog2(QDEPTH + N_CORES) + 1;
    localparam int CNT_W = $clog2(QDEPTH) + 1;

    slot_state_t          slot_st  [N_CORES];
    logic [JOB_ID_W-1:0]  slot_job [N_CORES];
    logic [RESULT_W-1:0]  slot_res [N_CORES];

    logic [N_CORES-1:0]   idle_mask;
    logic [N_CORES-1:0]   hold_mask;
    logic [N_CORES-1:0]   res_avail;
    logic [CW-1:0]        disp_ptr;
    logic [CW-1:0]        res_ptr;
    logic [CW-1:0]        disp_idx;
    logic [CW-1:0]        res_idx;
    int                   disp_pick;
    int                   res_pick;
    int                   res_from;

    logic                 fifo_full;
    logic                 fifo_empty;
    logic [JOB_ID_W-1:0]  fifo_head;
    logic [CNT_W-1:0]     fifo_count;
    logic                 accept;
    logic                 disp_go;
    logic                 xfer;

    function automatic int next_core(input int k);
        return (k == N_CORES - 1) ? 0 : k + 1;
    endfunction

    assign bus.job_ready = !fifo_full;
    assign accept        = bus.job_valid && !fifo_full;
    assign xfer          = bus.res_valid && bus.res_ready;

    core_dispatcher_job_fifo #(
        .DEPTH (QDEPTH),
        .W     (JOB_ID_W)
    ) u_job_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (accept),
        .din   (bus.job_id),
        .pop   (disp_go),
        .dout  (fifo_head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    for (genvar g = 0; g < N_CORES; g++) begin : g_job_out
        assign bus.core_job_id[g*JOB_ID_W +: JOB_ID_W] = slot_job[g];
    end

    always_comb begin
        idle_mask = '0;
        hold_mask = '0;
        for (int k = 0; k < N_CORES; k++) begin
            idle_mask[k] = (slot_st[k] == SLOT_IDLE);
            hold_mask[k] = (slot_st[k] == SLOT_HOLD);
        end
    end

    // Dispatch only looks at slots that are IDLE before this edge, so a slot
    // released by a result transfer waits one cycle before being reissued.
    always_comb begin
        disp_pick = rr_pick(MAX_CORES'(idle_mask), int'(disp_ptr), N_CORES);
        disp_go   = !fifo_empty && (disp_pick >= 0);
        disp_idx  = CW'(disp_pick);
    end

    // The result register reloads when empty or when its content is being
    // taken.  On a transfer the departing slot is masked out and the search
    // restarts just past it, which yields one result per cycle.
    always_comb begin
        res_avail = hold_mask;
        res_from  = int'(res_ptr);
        if (xfer) begin
            res_avail[bus.res_core] = 1'b0;
            res_from                = next_core(int'(bus.res_core));
        end
        res_pick = rr_pick(MAX_CORES'(res_avail), res_from, N_CORES);
        res_idx  = CW'(res_pick);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < N_CORES; k++) begin
                slot_st[k]  <= SLOT_IDLE;
                slot_job[k] <= '0;
            end
            bus.core_start <= '0;
            bus.res_valid  <= 1'b0;
            bus.res_id     <= '0;
            bus.res_core   <= '0;
            bus.res_value  <= '0;
            disp_ptr       <= '0;
            res_ptr        <= '0;
            outstanding    <= '0;
            idle           <= 1'b1;
            err_spurious   <= 1'b0;
        end else begin
            bus.core_start <= '0;

            // Completion: only a RUN slot may finish; anything else is flagged.
            for (int k = 0; k < N_CORES; k++) begin
                if (bus.core_done[k]) begin
                    if (slot_st[k] == SLOT_RUN) begin
                        slot_st[k]  <= SLOT_HOLD;
                        slot_res[k] <= bus.core_value[k*RESULT_W +: RESULT_W];
                    end else begin
                        err_spurious <= 1'b1;
                    end
                end
            end

            if (xfer) begin
                slot_st[bus.res_core] <= SLOT_IDLE;
                res_ptr               <= CW'(next_core(int'(bus.res_core)));
            end

            if (disp_go) begin
                slot_st[disp_idx]        <= SLOT_RUN;
                slot_job[disp_idx]       <= fifo_head;
                bus.core_start[disp_idx] <= 1'b1;
                disp_ptr                 <= CW'(next_core(int'(disp_idx)));
            end

            if (!bus.res_valid || bus.res_ready) begin
                if (res_pick >= 0) begin
                    bus.res_valid <= 1'b1;
                    bus.res_id    <= slot_job[res_idx];
                    bus.res_core  <= res_idx;
                    bus.res_value <= slot_res[res_idx];
                end else begin
                    bus.res_valid <= 1'b0;
                end
            end

            if (accept && !xfer)      outstanding <= outstanding + OUT_W'(1);
            else if (!accept && xfer) outstanding <= outstanding - OUT_W'(1);

            idle <= (fifo_count == '0) && (&idle_mask);
        end
    end

endmodule
